fs_inst_queue: RTL and testbench

//  Instruction queue between the IF stage and the ID stage. Buffers up to DEPTH

---
 rtl/fs_inst_queue.sv | 101 ++++++++++
 tb/tb_fs_inst_queue.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fs_inst_queue.sv
// In-order instruction queue between IF and ID. Registered allowin toward IF breaks
// the combinational ds_allowin -> fs_allowin path; blocks after an exception packet.
module fs_inst_queue #(
  parameter int DATA_W = 73,
  parameter int EXC_W  = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       fs2ds_valid,
  input  logic [DATA_W-1:0]          fs2ds_bus,
  output logic                       iq_allowin,
  output logic                       iq2ds_valid,
  output logic [DATA_W-1:0]          iq2ds_bus,
  input  logic                       ds_allowin,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     iq_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ex_block_q, ex_block_d;
  logic              full_s, empty_s, push_s, pop_s;

  function automatic logic pkt_exc(input logic [DATA_W-1:0] p);
    return (|p[DATA_W-1 -: EXC_W]) | p[0];
  endfunction

  assign full_s      = (cnt_q == CNT_W'(DEPTH));
  assign empty_s     = (cnt_q == {CNT_W{1'b0}});
  // allowin depends only on registers, so a same-cycle pop cannot make room for a push
  assign iq_allowin  = ~full_s & ~ex_block_q;
  assign push_s      = fs2ds_valid & iq_allowin & ~flush;
  assign iq2ds_valid = ~empty_s & ~flush;
  assign pop_s       = iq2ds_valid & ds_allowin;
  assign iq2ds_bus   = mem_q[rptr_q];
  assign iq_count    = cnt_q;

  // Next-state for pointers, occupancy and the exception block flag
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q;
    ex_block_d = ex_block_q;
    if (flush) begin
      wptr_d     = {PTR_W{1'b0}};
      rptr_d     = {PTR_W{1'b0}};
      cnt_d      = {CNT_W{1'b0}};
      ex_block_d = 1'b0;
    end else begin
      if (push_s) begin
        wptr_d = wptr_q + PTR_W'(1);
      end else begin
        wptr_d = wptr_q;
      end
      if (pop_s) begin
        rptr_d = rptr_q + PTR_W'(1);
      end else begin
        rptr_d = rptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
      if (push_s && pkt_exc(fs2ds_bus)) begin
        ex_block_d = 1'b1;
      end else begin
        ex_block_d = ex_block_q;
      end
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q     <= {PTR_W{1'b0}};
      rptr_q     <= {PTR_W{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      ex_block_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      ex_block_q <= ex_block_d;
    end
  end

  // Packet storage; contents are meaningless outside the occupied window
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wptr_q] <= fs2ds_bus;
    end
  end

endmodule

// File: tb/tb_fs_inst_queue.sv
// Directed bench for fs_inst_queue: a FIFO-level model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_fs_inst_queue;

  localparam int DW = 73;
  localparam int DEPTH = 4;

  logic          clk;
  logic          resetn;
  logic          fs2ds_valid;
  logic [DW-1:0] fs2ds_bus;
  logic          iq_allowin;
  logic          iq2ds_valid;
  logic [DW-1:0] iq2ds_bus;
  logic          ds_allowin;
  logic          flush;
  logic [2:0]    iq_count;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] mq[$];
  logic          mex;

  fs_inst_queue #(.DATA_W(DW), .EXC_W(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .fs2ds_valid(fs2ds_valid), .fs2ds_bus(fs2ds_bus),
    .iq_allowin(iq_allowin), .iq2ds_valid(iq2ds_valid), .iq2ds_bus(iq2ds_bus),
    .ds_allowin(ds_allowin), .flush(flush), .iq_count(iq_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] pkt(input logic [31:0] pc, input logic [7:0] exc,
                                        input logic adef);
    return {exc, pc ^ 32'hDEADBEEF, pc, adef};
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO with a capacity limit and an exception lock
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mq.delete();
      mex <= 1'b0;
    end else if (flush) begin
      mq.delete();
      mex <= 1'b0;
    end else begin
      bit do_push, do_pop;
      do_push = fs2ds_valid && (mq.size() < DEPTH) && !mex;
      do_pop  = (mq.size() > 0) && ds_allowin;
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back(fs2ds_bus);
        if (fs2ds_bus[72:65] != 8'h00 || fs2ds_bus[0]) mex <= 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model, mid-cycle
  always @(negedge clk) begin
    if (!resetn) begin
      chk("rst_valid", {72'd0, iq2ds_valid}, {DW{1'b0}});
      chk("rst_allowin", {72'd0, iq_allowin}, {72'd0, 1'b1});
      chk("rst_count", {70'd0, iq_count}, {DW{1'b0}});
    end else begin
      chk("allowin", {72'd0, iq_allowin}, {72'd0, (mq.size() < DEPTH) && !mex});
      chk("valid", {72'd0, iq2ds_valid}, {72'd0, (mq.size() > 0) && !flush});
      chk("count", {70'd0, iq_count}, DW'(mq.size()));
      if (mq.size() > 0 && !flush) chk("head_bus", iq2ds_bus, mq[0]);
    end
  end

  task automatic idle_inputs();
    fs2ds_valid = 1'b0;
    ds_allowin  = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic step(input logic v, input logic [DW-1:0] b, input logic dsa, input logic fl);
    fs2ds_valid = v;
    fs2ds_bus   = b;
    ds_allowin  = dsa;
    flush       = fl;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  initial begin
    resetn    = 1'b0;
    fs2ds_bus = {DW{1'b0}};
    idle_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("lit_rst_count", {70'd0, iq_count}, {DW{1'b0}});
    chk("lit_rst_allowin", {72'd0, iq_allowin}, {72'd0, 1'b1});
    chk("lit_rst_valid", {72'd0, iq2ds_valid}, {DW{1'b0}});
    resetn = 1'b1;

    // 1: three pushes, ID stalled
    step(1'b1, pkt(32'h1C000000, 8'h00, 1'b0), 1'b0, 1'b0);
    step(1'b1, pkt(32'h1C000004, 8'h00, 1'b0), 1'b0, 1'b0);
    step(1'b1, pkt(32'h1C000008, 8'h00, 1'b0), 1'b0, 1'b0);
    chk("t1_count", {70'd0, iq_count}, {70'd0, 3'd3});
    chk("t1_head_pc", {41'd0, iq2ds_bus[32:1]}, {41'd0, 32'h1C000000});
    chk("t1_allowin", {72'd0, iq_allowin}, {72'd0, 1'b1});

    // 2: fill, overflow attempt ignored, one pop reopens
    step(1'b1, pkt(32'h1C00000C, 8'h00, 1'b0), 1'b0, 1'b0);
    chk("t2_full_count", {70'd0, iq_count}, {70'd0, 3'd4});
    chk("t2_full_allowin", {72'd0, iq_allowin}, {DW{1'b0}});
    step(1'b1, pkt(32'h1C000010, 8'h00, 1'b0), 1'b0, 1'b0);
    chk("t2_ignored_count", {70'd0, iq_count}, {70'd0, 3'd4});
    step(1'b0, {DW{1'b0}}, 1'b1, 1'b0);
    chk("t2_pop_count", {70'd0, iq_count}, {70'd0, 3'd3});
    chk("t2_pop_allowin", {72'd0, iq_allowin}, {72'd0, 1'b1});
    chk("t2_new_head", {41'd0, iq2ds_bus[32:1]}, {41'd0, 32'h1C000004});

    // 3: drain, then a steady stream with one packet in flight
    for (int i = 0; i < 3; i++) step(1'b0, {DW{1'b0}}, 1'b1, 1'b0);
    chk("t3_drained", {70'd0, iq_count}, {DW{1'b0}});
    for (int k = 0; k < 6; k++) begin
      logic [31:0] pc;
      pc = 32'h1C000100 + 32'(k) * 32'd4;
      step(1'b1, pkt(pc, 8'h00, 1'b0), 1'b1, 1'b0);
      chk("t3_stream_count", {70'd0, iq_count}, {70'd0, 3'd1});
      chk("t3_stream_pc", {41'd0, iq2ds_bus[32:1]}, {41'd0, pc});
    end
    step(1'b0, {DW{1'b0}}, 1'b1, 1'b0);

    // 4: flush with simultaneous push and pop requests
    for (int i = 0; i < 3; i++)
      step(1'b1, pkt(32'h1C000200 + 32'(i) * 32'd4, 8'h00, 1'b0), 1'b0, 1'b0);
    fs2ds_valid = 1'b1;
    fs2ds_bus   = pkt(32'h1C00020C, 8'h00, 1'b0);
    ds_allowin  = 1'b1;
    flush       = 1'b1;
    #1;
    chk("t4_flush_valid", {72'd0, iq2ds_valid}, {DW{1'b0}});
    @(posedge clk);
    #1;
    idle_inputs();
    chk("t4_after_count", {70'd0, iq_count}, {DW{1'b0}});
    chk("t4_after_allowin", {72'd0, iq_allowin}, {72'd0, 1'b1});
    chk("t4_after_valid", {72'd0, iq2ds_valid}, {DW{1'b0}});

    // 5: adef and then tlb_exc packets lock the input until flush
    for (int e = 0; e < 2; e++) begin
      if (e == 0) step(1'b1, pkt(32'h1C000300, 8'h00, 1'b1), 1'b0, 1'b0);
      else        step(1'b1, pkt(32'h1C000304, 8'h01, 1'b0), 1'b0, 1'b0);
      chk("t5_blocked", {72'd0, iq_allowin}, {DW{1'b0}});
      step(1'b1, pkt(32'h1C000400, 8'h00, 1'b0), 1'b0, 1'b0);
      chk("t5_one_held", {70'd0, iq_count}, {70'd0, 3'd1});
      step(1'b1, pkt(32'h1C000404, 8'h00, 1'b0), 1'b1, 1'b0);
      chk("t5_drained", {70'd0, iq_count}, {DW{1'b0}});
      for (int i = 0; i < 3; i++) step(1'b0, {DW{1'b0}}, 1'b0, 1'b0);
      chk("t5_still_blocked", {72'd0, iq_allowin}, {DW{1'b0}});
      step(1'b0, {DW{1'b0}}, 1'b0, 1'b1);
      chk("t5_unblocked", {72'd0, iq_allowin}, {72'd0, 1'b1});
    end

    // 6: asynchronous reset in the middle of a stream
    step(1'b1, pkt(32'h1C000500, 8'h00, 1'b0), 1'b0, 1'b0);
    step(1'b1, pkt(32'h1C000504, 8'h00, 1'b0), 1'b0, 1'b0);
    chk("t6_pre_count", {70'd0, iq_count}, {70'd0, 3'd2});
    fs2ds_valid = 1'b1;
    fs2ds_bus   = pkt(32'h1C000508, 8'h00, 1'b0);
    ds_allowin  = 1'b1;
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_async_valid", {72'd0, iq2ds_valid}, {DW{1'b0}});
    chk("t6_async_count", {70'd0, iq_count}, {DW{1'b0}});
    idle_inputs();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_post_count", {70'd0, iq_count}, {DW{1'b0}});
    chk("t6_post_allowin", {72'd0, iq_allowin}, {72'd0, 1'b1});

    step(1'b0, {DW{1'b0}}, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
